bram_port_ctrl: RTL and testbench

//  Initiator for one port of the team's single-cycle-read block RAM. Converts a valid/ready

---
 rtl/bram_ctrl_pkg.sv | 15 +
 rtl/bram_rsp_fifo.sv | 59 +++++
 rtl/bram_port_ctrl.sv | 143 ++++++++++++++
 tb/tb_bram_port_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared types and helpers for the block-RAM port initiator.
// Holds the FSM state encoding and the width rule for the response-buffer occupancy count.
package bram_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Occupancy count must hold the value DEPTH itself, hence one extra bit.
    function automatic int unsigned rsp_cnt_bits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Small circular response buffer holding RAM read data until the client takes it.
// Power-of-two depth, so the pointers wrap by natural overflow.
module bram_rsp_fifo
    import bram_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = rsp_cnt_bits(DEPTH),
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;

    // NOTE: storage has no reset; an entry is only ever read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem[head];
    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_q == CW'(DEPTH)))
        else $error("bram_rsp_fifo overflow");

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && count_q == '0))
        else $error("bram_rsp_fifo underflow");

endmodule

// File: rtl/bram_port_ctrl.sv
// Initiator for one port of a single-cycle-read block RAM: turns a valid/ready request
// stream into RAM strobes and returns read data in order through a credit-limited buffer.
module bram_port_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned RAM_WIDTH     = 8,
    parameter int unsigned RAM_ADDR_BITS = 10,
    parameter bit          WDATA_LEAD    = 1'b1,
    parameter int unsigned RSP_DEPTH     = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [RAM_ADDR_BITS-1:0] req_addr_i,
    input  logic [RAM_WIDTH-1:0]     req_wdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [RAM_WIDTH-1:0]     rsp_rdata_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [RAM_ADDR_BITS-1:0] mem_addr_o,
    output logic [RAM_WIDTH-1:0]     mem_wdata_o,
    input  logic [RAM_WIDTH-1:0]     mem_rdata_i,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         rd_cnt_o,
    output logic [CNT_W-1:0]         wr_cnt_o
);

    localparam int unsigned CW = rsp_cnt_bits(RSP_DEPTH);
    localparam int unsigned OW = CW + 1;

    state_t                   state;
    state_t                   state_next;
    logic                     rd_issued;
    logic                     discard;
    logic                     inflight;
    logic                     preload;
    logic                     accept;
    logic                     rd_accept;
    logic                     pop;
    logic [CW-1:0]            rsp_count;
    logic [RAM_WIDTH-1:0]     head_data;
    logic [OW-1:0]            outstanding;
    logic [RAM_ADDR_BITS-1:0] addr_q;
    logic [RAM_ADDR_BITS-1:0] addr_d;
    logic [RAM_WIDTH-1:0]     wdata_q;
    logic [RAM_WIDTH-1:0]     wdata_d;

    // A read return from a write preload cycle is not a real response.
    assign inflight  = rd_issued && !discard;
    assign pop       = rsp_valid_o && rsp_ready_i;
    assign accept    = req_valid_i && req_ready_o;
    assign rd_accept = accept && !req_we_i;

    // An entry leaving this cycle frees its credit at once, so streaming reads run gap-free.
    assign outstanding = OW'(rsp_count) + OW'(inflight) - OW'(pop);
    assign req_ready_o = !rst_i && (state == IDLE) && (outstanding < OW'(RSP_DEPTH));

    assign rsp_valid_o = !rst_i && (rsp_count != '0);
    assign rsp_rdata_o = rst_i ? '0 : head_data;
    assign busy_o      = !rst_i && ((state != IDLE) || inflight || (rsp_count != '0));

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        mem_en_o   = 1'b0;
        mem_we_o   = 1'b0;
        preload    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (rst_i) begin
            state_next = IDLE;
            addr_d     = '0;
            wdata_d    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_en_o = 1'b1;
                        addr_d   = req_addr_i;
                        if (req_we_i) begin
                            wdata_d = req_wdata_i;
                            if (WDATA_LEAD) begin
                                preload    = 1'b1;
                                state_next = WRITE;
                            end else begin
                                mem_we_o = 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    // addr_q/wdata_q still hold what the preload cycle drove.
                    mem_en_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign mem_addr_o  = addr_d;
    assign mem_wdata_o = wdata_d;

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rd_issued <= 1'b0;
            discard   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_cnt_o  <= '0;
            wr_cnt_o  <= '0;
        end else begin
            state     <= state_next;
            rd_issued <= mem_en_o && !mem_we_o;
            discard   <= preload;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            if (rd_accept) rd_cnt_o <= rd_cnt_o + CNT_W'(1);
            if (mem_we_o)  wr_cnt_o <= wr_cnt_o + CNT_W'(1);
        end
    end

    bram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RAM_WIDTH)
    ) u_rsp_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (inflight),
        .wdata (mem_rdata_i),
        .pop   (pop),
        .rdata (head_data),
        .count (rsp_count)
    );

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Directed bench for bram_port_ctrl: one instance with write-data lead, one without,
// each paired with a behavioural single-cycle-read RAM.
module tb_bram_port_ctrl;

    logic        clk;
    logic        rst;
    logic        ram_init;

    logic        req_valid, req_ready, req_we;
    logic [9:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy;
    logic [15:0] rd_cnt, wr_cnt;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [9:0]  b_req_addr;
    logic [7:0]  b_req_wdata;
    logic        b_rsp_valid, b_rsp_ready;
    logic [7:0]  b_rsp_rdata;
    logic        b_mem_en, b_mem_we;
    logic [9:0]  b_mem_addr;
    logic [7:0]  b_mem_wdata, b_mem_rdata;
    logic        b_busy;
    logic [15:0] b_rd_cnt, b_wr_cnt;

    logic [7:0]  ram_a [1024];
    logic [7:0]  ram_b [1024];
    logic [7:0]  wlatch;
    logic [7:0]  exp_a [1024];

    int checks;
    int errors;

    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        v = 8'(a * 7 + 3);
        return v;
    endfunction

    bram_port_ctrl #(
        .RAM_WIDTH(8), .RAM_ADDR_BITS(10), .WDATA_LEAD(1'b1), .RSP_DEPTH(2), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
    );

    bram_port_ctrl #(
        .RAM_WIDTH(8), .RAM_ADDR_BITS(10), .WDATA_LEAD(1'b0), .RSP_DEPTH(2), .CNT_W(16)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
        .busy_o(b_busy), .rd_cnt_o(b_rd_cnt), .wr_cnt_o(b_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM that captures write data on the enabled read-type cycle before the write strobe.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram_a[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) begin
                ram_a[mem_addr] <= wlatch;
            end else begin
                mem_rdata <= ram_a[mem_addr];
                wlatch    <= mem_wdata;
            end
        end
    end

    // RAM that takes write data on the strobe cycle itself.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram_b[i] <= init_val(i);
        end else if (b_mem_en) begin
            if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
            else          b_mem_rdata <= ram_b[b_mem_addr];
        end
    end

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h003;
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 10'h007;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ram_init = 1'b0;
            #1;
            checks++;
            if ({req_ready, rsp_valid, mem_en, mem_we, busy, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got rdy=%b vld=%b en=%b we=%b busy=%b addr=%h wd=%h rd=%h expected all 0",
                         c, req_ready, rsp_valid, mem_en, mem_we, busy, mem_addr, mem_wdata, rsp_rdata);
            end
            checks++;
            if ({b_req_ready, b_mem_en, b_mem_we} !== 3'b000) begin
                errors++;
                $display("FAIL reset_outputs_b cycle %0d: got rdy/en/we=%b expected 000", c, {b_req_ready, b_mem_en, b_mem_we});
            end
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; b_req_valid = 1'b0;
        #1;
        checks++;
        if ({req_ready, b_req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 11", {req_ready, b_req_ready});
        end
        checks++;
        if ({rd_cnt, wr_cnt, busy} !== 33'd0) begin
            errors++;
            $display("FAIL reset_counters: got rd=%0d wr=%0d busy=%b expected 0 0 0", rd_cnt, wr_cnt, busy);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005; req_wdata = 8'hA5; rsp_ready = 1'b0;
        #1;
        checks++;
        if ({req_ready, mem_en, mem_we, mem_wdata} !== {1'b1, 1'b1, 1'b0, 8'hA5}) begin
            errors++;
            $display("FAIL wr_preload: got rdy=%b en=%b we=%b wd=%h expected 1 1 0 a5", req_ready, mem_en, mem_we, mem_wdata);
        end
        @(negedge clk);
        req_we = 1'b0;
        #1;
        checks++;
        if ({req_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, 1'b1, 10'h005, 8'hA5}) begin
            errors++;
            $display("FAIL wr_strobe: got rdy=%b en=%b we=%b addr=%h wd=%h expected 0 1 1 005 a5",
                     req_ready, mem_en, mem_we, mem_addr, mem_wdata);
        end
        exp_a[5] = 8'hA5;
        @(negedge clk);
        #1;
        checks++;
        if ({req_ready, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 10'h005}) begin
            errors++;
            $display("FAIL rd_accept: got rdy=%b en=%b we=%b addr=%h expected 1 1 0 005", req_ready, mem_en, mem_we, mem_addr);
        end
        checks++;
        if (wr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL wr_cnt_after_write: got %0d expected 1", wr_cnt);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, mem_en, mem_we, mem_addr} !== {1'b0, 1'b0, 1'b0, 10'h005}) begin
            errors++;
            $display("FAIL rd_latency1_idle_hold: got vld=%b en=%b we=%b addr=%h expected 0 0 0 005", rsp_valid, mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL rd_readback: got vld=%b data=%h expected 1 a5", rsp_valid, rsp_rdata);
        end
        checks++;
        if ({rd_cnt, wr_cnt} !== {16'd1, 16'd1}) begin
            errors++;
            $display("FAIL wr_rd_counters: got rd=%0d wr=%0d expected 1 1", rd_cnt, wr_cnt);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL wr_rd_drained: got vld=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_credit();
        int         acc;
        logic [7:0] q[$];
        acc = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = (acc < 4); req_we = 1'b0; req_addr = 10'h020 + acc[9:0];
            #1;
            if (req_valid && req_ready) begin
                q.push_back(exp_a[req_addr]);
                acc++;
            end
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL credit_accepts: got %0d expected 2", acc);
        end
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b011) begin
            errors++;
            $display("FAIL credit_stall: got rdy=%b vld=%b busy=%b expected 0 1 1", req_ready, rsp_valid, busy);
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        checks++;
        if (!rsp_valid || q.size() == 0 || rsp_rdata !== q[0]) begin
            errors++;
            $display("FAIL credit_pop_first: got vld=%b data=%h expected 1 %h", rsp_valid, rsp_rdata, exp_a[10'h020]);
        end
        if (q.size() != 0) void'(q.pop_front());
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 10'h020 + acc[9:0];
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_ready_again: got %b expected 1", req_ready);
        end
        if (req_ready) begin
            q.push_back(exp_a[req_addr]);
            acc++;
        end
        for (int c = 0; c < 20 && (acc < 4 || q.size() != 0); c++) begin
            @(negedge clk);
            rsp_ready = 1'b1; req_valid = (acc < 4); req_addr = 10'h020 + acc[9:0];
            #1;
            if (rsp_valid) begin
                checks++;
                if (q.size() == 0 || rsp_rdata !== q[0]) begin
                    errors++;
                    $display("FAIL credit_order: got %h expected %h", rsp_rdata, (q.size() != 0) ? q[0] : 8'h00);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (req_valid && req_ready) begin
                q.push_back(exp_a[req_addr]);
                acc++;
            end
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0;
        checks++;
        if (acc != 4 || q.size() != 0) begin
            errors++;
            $display("FAIL credit_complete: got accepted=%0d pending=%0d expected 4 0", acc, q.size());
        end
    endtask

    task automatic test_stream();
        int         issued;
        int         got;
        logic [7:0] q[$];
        issued = 0; got = 0;
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 1100 && got < 1024; c++) begin
            @(negedge clk);
            req_valid = (issued < 1024); req_we = 1'b0; req_addr = issued[9:0];
            #1;
            if (rsp_valid) begin
                checks++;
                if (q.size() == 0 || rsp_rdata !== q[0]) begin
                    errors++;
                    $display("FAIL stream_data[%0d]: got %h expected %h", got, rsp_rdata, (q.size() != 0) ? q[0] : 8'h00);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            if (req_valid) begin
                checks++;
                if (req_ready !== 1'b1 || mem_addr !== req_addr) begin
                    errors++;
                    $display("FAIL stream_accept addr %h: got rdy=%b mem_addr=%h expected 1 %h", req_addr, req_ready, mem_addr, req_addr);
                end else begin
                    q.push_back(exp_a[issued]);
                    issued++;
                end
            end
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        checks++;
        if (issued != 1024 || got != 1024) begin
            errors++;
            $display("FAIL stream_totals: got issued=%0d returned=%0d expected 1024 1024", issued, got);
        end
        checks++;
        if ({rd_cnt, busy} !== {16'd1024, 1'b0}) begin
            errors++;
            $display("FAIL stream_rd_cnt: got rd=%0d busy=%b expected 1024 0", rd_cnt, busy);
        end
    endtask

    task automatic test_reset_in_write();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h010; req_wdata = 8'h3C; rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstw_accept: got %b expected 1", req_ready);
        end
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we} !== 2'b00) begin
            errors++;
            $display("FAIL rstw_no_strobe: got en/we=%b expected 00", {mem_en, mem_we});
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010;
        #1;
        checks++;
        if ({req_ready, wr_cnt} !== {1'b1, 16'd0}) begin
            errors++;
            $display("FAIL rstw_after: got rdy=%b wr=%0d expected 1 0", req_ready, wr_cnt);
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, exp_a[10'h010]}) begin
            errors++;
            $display("FAIL rstw_old_data: got vld=%b data=%h expected 1 %h", rsp_valid, rsp_rdata, exp_a[10'h010]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_lead0();
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 10'h3FF; b_req_wdata = 8'hFF; b_rsp_ready = 1'b0;
        #1;
        checks++;
        if ({b_req_ready, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata} !== {1'b1, 1'b1, 1'b1, 10'h3FF, 8'hFF}) begin
            errors++;
            $display("FAIL lead0_write: got rdy=%b en=%b we=%b addr=%h wd=%h expected 1 1 1 3ff ff",
                     b_req_ready, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata);
        end
        @(negedge clk);
        b_req_we = 1'b0;
        #1;
        checks++;
        if ({b_req_ready, b_mem_en, b_mem_we, b_wr_cnt} !== {1'b1, 1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL lead0_read_next: got rdy=%b en=%b we=%b wr=%0d expected 1 1 0 1", b_req_ready, b_mem_en, b_mem_we, b_wr_cnt);
        end
        @(negedge clk);
        b_req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({b_rsp_valid, b_rsp_rdata, b_rd_cnt} !== {1'b1, 8'hFF, 16'd1}) begin
            errors++;
            $display("FAIL lead0_readback: got vld=%b data=%h rd=%0d expected 1 ff 1", b_rsp_valid, b_rsp_rdata, b_rd_cnt);
        end
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
        #1;
        checks++;
        if ({b_rsp_valid, b_busy} !== 2'b00) begin
            errors++;
            $display("FAIL lead0_drained: got vld=%b busy=%b expected 0 0", b_rsp_valid, b_busy);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; ram_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) exp_a[i] = init_val(i);
        test_reset();
        test_write_read();
        test_credit();
        test_stream();
        test_reset_in_write();
        test_lead0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
